// File: rtl/inst_axi_rd_bridge_if.sv
// Bus bundles for the fetch-side SRAM-like port and the AXI4 read channels
// used by inst_axi_rd_bridge.

interface inst_sram_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );

  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );
endinterface

interface axi_rd_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/inst_axi_rd_bridge.sv
// SRAM-like instruction fetch port to single-ID AXI4 read master, with a
// registered AR stage, an in-order response FIFO and an outstanding cap.

module inst_axi_rd_bridge #(
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [3:0]  ARID            = 4'd0
) (
  input  logic      clk,
  input  logic      reset,
  inst_sram_if.slave sram,
  axi_rd_if.master   axi
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  logic             arvalid_reg;
  logic [31:0]      araddr_reg;
  logic [1:0]       arsize_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] occ_reg, occ_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [31:0]      mem_reg [MAX_OUTSTANDING];

  logic accept;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // The AR register may reload in the same cycle it hands off, so accept
  // looks at arready as well as the current arvalid.
  assign accept = sram.inst_sram_req & ~sram.inst_sram_wr &
                  (~arvalid_reg | axi.arready) & (cnt_reg < MAX_CNT);

  assign fifo_full  = (occ_reg == MAX_CNT);
  assign fifo_empty = (occ_reg == '0);
  assign push       = axi.rvalid & ~fifo_full;
  assign pop        = ~fifo_empty;

  always_comb begin
    cnt_next    = cnt_reg;
    occ_next    = occ_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    case ({accept, pop})
      2'b10:   cnt_next = cnt_reg + 1'b1;
      2'b01:   cnt_next = cnt_reg - 1'b1;
      default: cnt_next = cnt_reg;
    endcase
    case ({push, pop})
      2'b10:   occ_next = occ_reg + 1'b1;
      2'b01:   occ_next = occ_reg - 1'b1;
      default: occ_next = occ_reg;
    endcase
    if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
    if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arvalid_reg <= 1'b0;
      araddr_reg  <= '0;
      arsize_reg  <= '0;
      cnt_reg     <= '0;
      occ_reg     <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
    end else begin
      if (accept) begin
        arvalid_reg <= 1'b1;
        araddr_reg  <= sram.inst_sram_addr;
        arsize_reg  <= sram.inst_sram_size;
      end else if (arvalid_reg && axi.arready) begin
        arvalid_reg <= 1'b0;
      end
      cnt_reg    <= cnt_next;
      occ_reg    <= occ_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Payload storage needs no reset; validity is tracked by occ_reg.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= axi.rdata;
  end

  assign sram.inst_sram_addr_ok = accept;
  assign sram.inst_sram_data_ok = ~fifo_empty;
  assign sram.inst_sram_rdata   = fifo_empty ? 32'd0 : mem_reg[rd_ptr_reg];

  assign axi.arid    = ARID;
  assign axi.araddr  = araddr_reg;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = {1'b0, arsize_reg};
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = arvalid_reg;
  assign axi.rready  = ~fifo_full;

  logic unused_inputs;
  assign unused_inputs = ^{sram.inst_sram_wstrb, sram.inst_sram_wdata,
                           axi.rid, axi.rresp, axi.rlast};

endmodule
